// File: rtl/exec_seq_pkg.sv
// Shared types, opcode constants and latency lookup for the execute sequencer.
package exec_seq_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} seq_state_e;

  localparam logic [6:0] OP_REG        = 7'b0110011;
  localparam logic [6:0] OP_REG32      = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [31:0] instruction;
    logic        jump_signal;
    logic        reg_write;
    logic        mem_write;
  } control_signals_struct;

  // RV64M ops take the multi-cycle path; instruction[14] is funct3[2] (0 = mul, 1 = div/rem).
  function automatic int unsigned op_latency(control_signals_struct ctrl,
                                             int unsigned mul_latency,
                                             int unsigned div_latency);
    logic [6:0] opc;
    opc = ctrl.instruction[6:0];
    if ((opc == OP_REG || opc == OP_REG32) && ctrl.instruction[31:25] == FUNCT7_MULDIV) begin
      return ctrl.instruction[14] ? div_latency : mul_latency;
    end
    return 1;
  endfunction

endpackage

// File: rtl/execute_sequencer_if.sv
// Decode, executor, EX/MEM and redirect signals of the execute sequencer.
interface execute_sequencer_if;
  import exec_seq_pkg::*;

  logic                  flush_in;
  logic                  id_valid;
  logic                  id_ready;
  control_signals_struct id_ctrl;
  logic [63:0]           id_pc;
  logic [63:0]           id_reg_a;
  logic [63:0]           id_reg_b;

  control_signals_struct op_ctrl;
  logic [63:0]           op_pc;
  logic [63:0]           op_reg_a;
  logic [63:0]           op_reg_b;

  logic                  exec_enable;
  logic                  exec_done;
  logic [63:0]           exec_alu_data;
  logic [63:0]           exec_target;
  control_signals_struct exec_ctrl;

  logic                  ex_valid;
  logic                  ex_ready;
  control_signals_struct ex_ctrl;
  logic [63:0]           ex_alu_data;
  logic [63:0]           ex_reg_b;

  logic                  redirect_valid;
  logic [63:0]           redirect_pc;
  logic                  flush_upstream;
  logic                  busy;

  modport master (
    input  flush_in, id_valid, id_ctrl, id_pc, id_reg_a, id_reg_b,
    input  exec_done, exec_alu_data, exec_target, exec_ctrl, ex_ready,
    output id_ready, op_ctrl, op_pc, op_reg_a, op_reg_b, exec_enable,
    output ex_valid, ex_ctrl, ex_alu_data, ex_reg_b,
    output redirect_valid, redirect_pc, flush_upstream, busy
  );

  modport slave (
    output flush_in, id_valid, id_ctrl, id_pc, id_reg_a, id_reg_b,
    output exec_done, exec_alu_data, exec_target, exec_ctrl, ex_ready,
    input  id_ready, op_ctrl, op_pc, op_reg_a, op_reg_b, exec_enable,
    input  ex_valid, ex_ctrl, ex_alu_data, ex_reg_b,
    input  redirect_valid, redirect_pc, flush_upstream, busy
  );

endinterface

// File: rtl/exec_latency_counter.sv
// Loadable down-counter tracking remaining executor enable cycles; clear wins over load.
module exec_latency_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/execute_sequencer.sv
// Sequences one decoded op through the executor for its latency, holds the result in the
// EX/MEM register and issues a registered PC redirect for taken jumps/branches.
module execute_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 8
) (
  input logic                 clk,
  input logic                 reset,
  execute_sequencer_if.master bus
);

  localparam int unsigned MaxLat = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  seq_state_e state_q, state_d;

  control_signals_struct op_ctrl_q, ex_ctrl_q;
  logic [63:0] op_pc_q, op_reg_a_q, op_reg_b_q;
  logic [63:0] ex_alu_data_q, ex_reg_b_q, redirect_pc_q;
  logic        redirect_valid_q;

  logic            id_ready;
  logic            exec_enable;
  logic            accept;
  logic            finish;
  logic            cnt_zero;
  logic [CntW-1:0] cnt_load_val;

  always_comb begin
    cnt_load_val = CntW'(op_latency(bus.id_ctrl, MUL_LATENCY, DIV_LATENCY) - 1);
  end

  exec_latency_counter #(
    .Width(CntW)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(cnt_load_val),
    .dec     (exec_enable),
    .clear   (bus.flush_in),
    .zero    (cnt_zero)
  );

  // Output decode: the op visible during a redirect cycle is wrong-path, so it is refused.
  always_comb begin
    id_ready    = 1'b0;
    exec_enable = 1'b0;
    unique case (state_q)
      IDLE: id_ready = 1'b1;
      EXEC: exec_enable = 1'b1;
      HOLD: id_ready = bus.ex_ready && !redirect_valid_q;
      default: ;
    endcase
  end

  assign accept = bus.id_valid && id_ready && !bus.flush_in;
  assign finish = exec_enable && cnt_zero && bus.exec_done && !bus.flush_in;

  always_comb begin
    state_d = state_q;
    if (bus.flush_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = EXEC;
        EXEC: if (finish) state_d = HOLD;
        HOLD: begin
          if (accept) begin
            state_d = EXEC;
          end else if (bus.ex_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_ctrl_q        <= '0;
      op_pc_q          <= '0;
      op_reg_a_q       <= '0;
      op_reg_b_q       <= '0;
      ex_ctrl_q        <= '0;
      ex_alu_data_q    <= '0;
      ex_reg_b_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= finish && bus.exec_ctrl.jump_signal;
      if (accept) begin
        op_ctrl_q  <= bus.id_ctrl;
        op_pc_q    <= bus.id_pc;
        op_reg_a_q <= bus.id_reg_a;
        op_reg_b_q <= bus.id_reg_b;
      end
      if (finish) begin
        ex_ctrl_q     <= bus.exec_ctrl;
        ex_alu_data_q <= bus.exec_alu_data;
        ex_reg_b_q    <= op_reg_b_q;
        if (bus.exec_ctrl.jump_signal) begin
          redirect_pc_q <= bus.exec_target;
        end
      end
    end
  end

  assign bus.id_ready       = id_ready;
  assign bus.exec_enable    = exec_enable;
  assign bus.busy           = (state_q != IDLE);
  assign bus.ex_valid       = (state_q == HOLD);
  assign bus.op_ctrl        = op_ctrl_q;
  assign bus.op_pc          = op_pc_q;
  assign bus.op_reg_a       = op_reg_a_q;
  assign bus.op_reg_b       = op_reg_b_q;
  assign bus.ex_ctrl        = ex_ctrl_q;
  assign bus.ex_alu_data    = ex_alu_data_q;
  assign bus.ex_reg_b       = ex_reg_b_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_upstream = redirect_valid_q;

endmodule
